// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Purpose  : Shared types and constants for the binary to two-digit
//            seven-segment decoder.
// Contents : seg_t      - 7-bit segment vector, bit 0 = a ... bit 6 = g
//            SEG_BLANK  - all segments off (active-low)
//            DIGIT_SEG  - active-low patterns for digits 0..9
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  typedef logic [6:0] seg_t;

  // Segments are active-low, so a blank display drives every line high.
  localparam seg_t SEG_BLANK = 7'b1111111;

  // Patterns written g..a (bit 6 down to bit 0).
  localparam seg_t DIGIT_SEG [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/seg7_digit.sv
`default_nettype none
// ============================================================================
// Module   : seg7_digit
// Purpose  : Combinational BCD digit to active-low seven-segment encoder.
//            Codes 10..15 are not decimal digits and produce a blank.
// Ports    : bcd  in  4  digit code 0..9
//            seg  out 7  active-low segments, bit 0 = a ... bit 6 = g
// Revision : 1.0 - initial release
// ============================================================================
module seg7_digit
  import decoder_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = DIGIT_SEG[0];
      4'd1:    seg = DIGIT_SEG[1];
      4'd2:    seg = DIGIT_SEG[2];
      4'd3:    seg = DIGIT_SEG[3];
      4'd4:    seg = DIGIT_SEG[4];
      4'd5:    seg = DIGIT_SEG[5];
      4'd6:    seg = DIGIT_SEG[6];
      4'd7:    seg = DIGIT_SEG[7];
      4'd8:    seg = DIGIT_SEG[8];
      4'd9:    seg = DIGIT_SEG[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : seg7_digit
`default_nettype wire

// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
// Module   : decoder
// Purpose  : Splits a 4-bit unsigned value (0..15) into tens and units
//            digits and drives two registered active-low 7-segment displays.
//            Latency is one clock; reset blanks both displays immediately.
// Ports    : clk     in  1  system clock, rising edge
//            rst     in  1  asynchronous active-high reset
//            binary  in  4  value to display, 0..15
//            seg0    out 7  units digit, active-low, bit 0 = a ... bit 6 = g
//            seg1    out 7  tens digit, same encoding as seg0
// Revision : 1.0 - initial release
// ============================================================================
module decoder
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] binary,
  output seg_t       seg0,
  output seg_t       seg1
);

  logic       tens_flag;
  logic [3:0] units_bcd;
  logic [3:0] tens_bcd;
  seg_t       units_seg;
  seg_t       tens_seg;

  // With a 4-bit input the tens digit can only be 0 or 1, so a single
  // compare and a conditional subtract replace a general divide.
  always_comb begin
    tens_flag = (binary >= 4'd10);
    units_bcd = tens_flag ? (binary - 4'd10) : binary;
    tens_bcd  = {3'b000, tens_flag};
  end

  seg7_digit u_units (
    .bcd (units_bcd),
    .seg (units_seg)
  );

  seg7_digit u_tens (
    .bcd (tens_bcd),
    .seg (tens_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg0 <= SEG_BLANK;
      seg1 <= SEG_BLANK;
    end else begin
      seg0 <= units_seg;
      seg1 <= tens_seg;
    end
  end

endmodule : decoder
`default_nettype wire

// File: tb/tb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder
// Purpose  : Self-checking bench for decoder. Expected displays come from a
//            decimal model (value / 10, value % 10) and a digit pattern table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] binary;
  logic [6:0] seg0;
  logic [6:0] seg1;

  int checks;
  int failures;

  decoder dut (
    .clk    (clk),
    .rst    (rst),
    .binary (binary),
    .seg0   (seg0),
    .seg1   (seg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] BLANK = 7'b1111111;

  // Reference pattern for a decimal digit, g..a.
  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [6:0] exp_units(input int v);
    return pattern(v % 10);
  endfunction

  function automatic logic [6:0] exp_tens(input int v);
    return pattern(v / 10);
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_value(input string tag, input int v);
    check({tag, "_seg0"}, seg0, exp_units(v));
    check({tag, "_seg1"}, seg1, exp_tens(v));
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    int prev;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    binary   = 4'd7;

    // Asynchronous reset: asserted between edges, checked before any edge.
    #1 rst = 1'b1;
    #1;
    check("reset_async_seg0", seg0, BLANK);
    check("reset_async_seg1", seg1, BLANK);

    tick();
    check("reset_hold_seg0", seg0, BLANK);
    check("reset_hold_seg1", seg1, BLANK);

    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_no_edge_seg0", seg0, BLANK);
    check("release_no_edge_seg1", seg1, BLANK);
    tick();
    check_value("first_edge_7", 7);

    // Sweep 0..15 then wrap to 0; each value lands one edge later.
    prev = 7;
    for (int i = 0; i <= 16; i++) begin
      v = i % 16;
      @(negedge clk);
      binary = 4'(v);
      #1;
      check_value("latency_hold", prev);
      tick();
      check_value("sweep", v);
      prev = v;
    end

    // Explicit 9->10 boundary and 15->0 wrap.
    @(negedge clk); binary = 4'd9;  tick(); check_value("bound_9", 9);
    @(negedge clk); binary = 4'd10; tick(); check_value("bound_10", 10);
    @(negedge clk); binary = 4'd15; tick(); check_value("wrap_15", 15);
    @(negedge clk); binary = 4'd0;  tick(); check_value("wrap_0", 0);

    // Stable input: outputs stay put over further edges.
    tick();
    check_value("stable_0", 0);

    // Randomized back-to-back values.
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(15, 0));
      @(negedge clk);
      binary = 4'(v);
      tick();
      check_value("random", v);
    end

    // Mid-run reset with binary = 14.
    @(negedge clk); binary = 4'd14; tick();
    check_value("pre_reset_14", 14);
    #2 rst = 1'b1;
    #1;
    check("midreset_async_seg0", seg0, BLANK);
    check("midreset_async_seg1", seg1, BLANK);
    tick();
    check("midreset_hold_seg0", seg0, BLANK);
    check("midreset_hold_seg1", seg1, BLANK);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_release_seg0", seg0, BLANK);
    check("midreset_release_seg1", seg1, BLANK);
    tick();
    check_value("after_midreset_14", 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_decoder
`default_nettype wire
